mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the core's instruction-fetch requester and its data (load/store) requester.
- Pipelined: one access can be issued per cycle. Read data returns one cycle after issue, routed back to the requester that issued it.
- Data accesses win contention by default. A streak counter guarantees fetch progress under sustained load/store traffic.
- Sits between the core's instr_*/data_* ports and the unified memory macro.

---
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// and data (load/store) requesters. One access issues per cycle. Read data
// comes back one cycle later and is steered to whichever requester issued it.
// Data wins contention, but a streak counter forces a fetch through after
// MAX_STREAK consecutive contested data grants.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,

  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,

  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] MAX_Q = SW'(MAX_STREAK);

  typedef enum logic {
    OWNER_DATA  = 1'b0,
    OWNER_FETCH = 1'b1
  } owner_t;

  logic [SW-1:0] streak_q;
  logic          resp_valid_q;
  owner_t        resp_owner_q;

  logic data_win;
  logic fetch_win;
  logic issue;

  // Pick the winner: data by default, fetch when alone or when the streak
  // has reached its limit. Reset suppresses any issue.
  always_comb begin
    data_win  = 1'b0;
    fetch_win = 1'b0;
    if (!rst) begin
      if (d_req && (!i_req || (streak_q < MAX_Q))) begin
        data_win = 1'b1;
      end else if (i_req) begin
        fetch_win = 1'b1;
      end
    end
  end

  assign issue = data_win | fetch_win;
  assign i_gnt = fetch_win;
  assign d_gnt = data_win;

  // Memory port is driven straight from the winner; write data always comes
  // from the data side since fetch never writes.
  always_comb begin
    mem_en    = issue;
    mem_we    = data_win & d_we;
    mem_addr  = data_win ? d_addr : i_addr;
    mem_wdata = d_wdata;
  end

  // Count consecutive data grants that made a waiting fetch lose.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else if (data_win && i_req) begin
      streak_q <= (streak_q == MAX_Q) ? MAX_Q : streak_q + 1'b1;
    end else if (fetch_win || !i_req) begin
      streak_q <= '0;
    end
  end

  // Remember whether a read was issued and for whom, so the returning data
  // can be tagged one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWNER_DATA;
    end else begin
      resp_valid_q <= issue & ~mem_we;
      resp_owner_q <= fetch_win ? OWNER_FETCH : OWNER_DATA;
    end
  end

  assign i_rvalid = resp_valid_q && (resp_owner_q == OWNER_FETCH);
  assign d_rvalid = resp_valid_q && (resp_owner_q == OWNER_DATA);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a small synchronous memory model
// attached to the memory port.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [XLEN-1:0] i_rdata;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory: reads land one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[11:2]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dd);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  string pattern;

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    mem[32'h100 >> 2] = 32'h00500093;
    mem[32'h104 >> 2] = 32'h00A00113;
    mem[32'h108 >> 2] = 32'h00000022;
    mem[32'h300 >> 2] = 32'h00000011;
    mem_rdata = 32'h0;

    // Reset with both requesters asserting.
    rst = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 32'h0);
    for (int c = 0; c < 2; c++) begin
      checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
      checkOutput("rst_i_gnt", 32'(i_gnt), 32'd0);
      checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      tick();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("post_rst_i_rvalid", 32'(i_rvalid), 32'd0);
    checkOutput("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("post_rst_streak", 32'(dut.streak_q), 32'd0);
    tick();

    // Lone fetch.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("fetch_i_gnt", 32'(i_gnt), 32'd1);
    checkOutput("fetch_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("fetch_mem_en", 32'(mem_en), 32'd1);
    checkOutput("fetch_mem_addr", mem_addr, 32'h100);
    checkOutput("fetch_mem_we", 32'(mem_we), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("fetch_i_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("fetch_i_rdata", i_rdata, 32'h00500093);
    checkOutput("fetch_d_rvalid", 32'(d_rvalid), 32'd0);
    tick();

    // Contention: data write beats fetch, fetch follows next cycle.
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
    checkOutput("cont_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("cont_i_gnt", 32'(i_gnt), 32'd0);
    checkOutput("cont_mem_we", 32'(mem_we), 32'd1);
    checkOutput("cont_mem_addr", mem_addr, 32'h200);
    checkOutput("cont_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("cont_wr_i_rvalid", 32'(i_rvalid), 32'd0);
    checkOutput("cont_wr_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("cont_streak", 32'(dut.streak_q), 32'd1);
    checkOutput("cont_next_i_gnt", 32'(i_gnt), 32'd1);
    checkOutput("cont_next_mem_addr", mem_addr, 32'h104);
    checkOutput("cont_next_mem_we", 32'(mem_we), 32'd0);
    checkOutput("cont_mem_written", mem[32'h200 >> 2], 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("cont_i_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("cont_i_rdata", i_rdata, 32'h00A00113);
    checkOutput("cont_streak_clr", 32'(dut.streak_q), 32'd0);
    tick();

    // Starvation guard: fetch forced through after four contested data grants.
    pattern = "DDDDIDDDDI";
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 32'h400, 32'(c));
      checkOutput($sformatf("starve_streak_%0d", c), 32'(dut.streak_q),
                  (pattern[c] == "I") ? 32'd4 : 32'(c % 5));
      checkOutput($sformatf("starve_d_gnt_%0d", c), 32'(d_gnt),
                  (pattern[c] == "D") ? 32'd1 : 32'd0);
      checkOutput($sformatf("starve_i_gnt_%0d", c), 32'(i_gnt),
                  (pattern[c] == "I") ? 32'd1 : 32'd0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("starve_streak_end", 32'(dut.streak_q), 32'd0);
    checkOutput("starve_last_i_rvalid", 32'(i_rvalid), 32'd1);
    tick();

    // Pipelined ordering: data read then fetch read on consecutive cycles.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    checkOutput("pipe_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("pipe_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("pipe_d_rdata", d_rdata, 32'h00000011);
    checkOutput("pipe_i_rvalid_early", 32'(i_rvalid), 32'd0);
    checkOutput("pipe_i_gnt", 32'(i_gnt), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("pipe_i_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("pipe_i_rdata", i_rdata, 32'h00000022);
    checkOutput("pipe_d_rvalid_late", 32'(d_rvalid), 32'd0);
    tick();

    // Reset mid-operation: build a streak, issue a read, then reset.
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 32'h204, 32'h12345678);
    tick();
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 32'h0);
    checkOutput("midrst_streak_pre", 32'(dut.streak_q), 32'd1);
    checkOutput("midrst_d_gnt", 32'(d_gnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_gnt_forced", 32'(d_gnt), 32'd0);
    checkOutput("midrst_mem_en_forced", 32'(mem_en), 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("midrst_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("midrst_i_rvalid", 32'(i_rvalid), 32'd0);
    checkOutput("midrst_streak", 32'(dut.streak_q), 32'd0);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("resume_i_gnt", 32'(i_gnt), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("resume_i_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("resume_i_rdata", i_rdata, 32'h00500093);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
